carfield_domain_sequencer: RTL
==============================

Name: carfield_domain_sequencer

Overview:
- Power/clock/reset sequencer for the Carfield accelerator domains: Safety Island, Security Island and Integer Cluster.
- Each domain has its own FSM that sequences clock enable, reset release and isolation on power-up, and isolate, drain, reset and clock-off on power-down.
- A round-robin scheduler lets only one domain transition at a time, which bounds inrush current and reset glitches on the shared interconnect.
- Sits beside the Cheshire regbus register file, which drives en_i and reads the status outputs.

Parameters:
- NumDomains, 3, number of sequenced domains; index order SafetyIsland=0, SecurityIsland=1, IntCluster=2.
- SettleCycles, 16, cycles the clock runs with reset held before reset release; must be >=1.
- RstCycles, 8, cycles spent in each reset-related phase (release wait and re-assert); must be >=1.
- DrainTimeout, 1024, maximum cycles to wait for idle_i during power-down; must be >=1.

Ports:
- clk_i  in  1  system clock; the only clock.
- rst_i  in  1  synchronous, active-high reset.
- en_i  in  NumDomains  requested domain state per bit; 1=on, 0=off; level-sensitive.
- idle_i  in  NumDomains  domain reports no outstanding AXI transactions.
- clr_timeout_i  in  NumDomains  one-cycle pulse that clears timeout_o.
- clk_en_o  out  NumDomains  domain clock-gate enable.
- domain_rst_o  out  NumDomains  domain reset, active-high.
- isolate_o  out  NumDomains  clamps the domain AXI/IRQ boundary; 1=isolated.
- on_o  out  NumDomains  domain fully on.
- busy_o  out  NumDomains  domain mid-transition.
- timeout_o  out  NumDomains  sticky flag: drain timed out.

Behaviour:
- Reset is synchronous and active-high on rst_i. All outputs are registered.
- Reset values: every FSM in OFF, clk_en_o=0, domain_rst_o=all 1, isolate_o=all 1, on_o=0, busy_o=0, timeout_o=0, RR pointer=0.
- FSM states and outputs (clk_en, rst, iso):
  - OFF: 0,1,1.
  - CLK_ON: 1,1,1; lasts SettleCycles cycles.
  - RST_REL: 1,0,1; lasts RstCycles cycles.
  - ON: 1,0,0; on_o=1.
  - DRAIN: 1,0,1.
  - RST_ASSERT: 1,1,1; lasts RstCycles cycles.
- busy_o=1 in every state except OFF and ON.
- Request: domain d requests when (OFF and en_i[d]=1) or (ON and en_i[d]=0).
- Scheduler:
  - Combinational grant to the first requester at or after the RR pointer, and only when no domain holds the token.
  - The granted FSM leaves its stable state on the next edge.
  - The token is held until that FSM reaches OFF or ON; it is freed in that same cycle.
  - The pointer then moves to the granted index + 1, mod NumDomains.
  - A request that loses arbitration waits; it is never dropped.
- Power-up: en_i[d] rises at cycle 0 with the token free.
  - Cycle 1: CLK_ON.
  - Cycle 1+SettleCycles: RST_REL.
  - Cycle 1+SettleCycles+RstCycles: ON.
- Power-down: en_i[d] falls at cycle 0 with the token free.
  - Cycle 1: DRAIN, on_o=0.
  - Exit DRAIN on the cycle after idle_i[d] is sampled high.
  - If idle_i never rises, exit after DrainTimeout DRAIN cycles. timeout_o[d] sets on the same edge as RST_ASSERT entry.
  - RST_ASSERT lasts RstCycles cycles, then OFF.
- Sequences are never aborted. If en_i changes mid-transition, the FSM completes to its stable state and then re-requests on the new level.
- Timeout flag: clr_timeout_i clears timeout_o; if a set and a clear occur in the same cycle, the set wins.
- rst_i asserted mid-sequence forces reset values on the next edge, including outputs and the RR pointer.
- Counters: one down-counter per FSM, width $clog2(max(SettleCycles,RstCycles,DrainTimeout)+1). It is loaded on state entry and no wrap is possible.
- idle_i is ignored in every state except DRAIN.

Decomposition:
- carfield_pkg gains:
  - carfield_domain_e: SafetyIslandDomIdx=0, SecurityIslandDomIdx=1, IntClusterDomIdx=2.
  - carfield_dom_state_e: OFF, CLK_ON, RST_REL, ON, DRAIN, RST_ASSERT.
  - NumDomains = 3.
- Sub-module carfield_domain_fsm holds one domain's FSM and counter. It has req_o/gnt_i toward the scheduler.
- The scheduler and the generate loop live in the top module.
- Elaboration-time assertions: SettleCycles, RstCycles and DrainTimeout >= 1.

Test Plan:
- Reset: hold rst_i for 2 cycles with en_i=3'b111 asserted throughout. Required: all outputs stay at reset values while rst_i is high. After release, domain 0 is granted first and clk_en_o=3'b001 at cycle 1.
- Single power-up, defaults, en_i[2]=1 at cycle 0. Required: clk_en_o[2]=1 at cycle 1, domain_rst_o[2]=0 at cycle 17, isolate_o[2]=0 and on_o[2]=1 at cycle 25.
- Serialisation: en_i=3'b111 at cycle 0.
  - Domains power up in order 0, 1, 2.
  - on_o[0] at cycle 25, on_o[1] at cycle 50, on_o[2] at cycle 75.
  - busy_o never has more than one bit high at a time.
- Drain with idle: domain 1 ON; drop en_i[1] at cycle 0; idle_i[1]=1 from cycle 3.
  - Required: DRAIN during cycles 1–3, RST_ASSERT at cycle 4, clk_en_o[1]=0 at cycle 12.
  - timeout_o[1] stays 0.
- Drain timeout: DrainTimeout=4 and idle_i[0]=0 throughout.
  - RST_ASSERT and timeout_o[0]=1 at cycle 5.
  - clr_timeout_i pulsed in the same cycle leaves timeout_o[0]=1; a later pulse clears it.
- Mid-sequence change: drop en_i[0] at cycle 5 of power-up.
  - Required: ON is still reached at cycle 25.
  - DRAIN is entered at cycle 26, provided no other domain is requesting.

Source files
------------

// File: rtl/carfield_pkg.sv
// carfield_pkg
//   Shared types and constants for the Carfield domain power/clock/reset
//   sequencer: domain index enumeration, per-domain FSM state encoding and
//   the round-robin pointer helper.
package carfield_pkg;

  localparam int unsigned NumDomains = 3;
  localparam int unsigned DomIdxW    = $clog2(NumDomains);

  typedef enum logic [1:0] {
    SafetyIslandDomIdx   = 2'd0,
    SecurityIslandDomIdx = 2'd1,
    IntClusterDomIdx     = 2'd2
  } carfield_domain_e;

  typedef enum logic [2:0] {
    OFF        = 3'd0,
    CLK_ON     = 3'd1,
    RST_REL    = 3'd2,
    ON         = 3'd3,
    DRAIN      = 3'd4,
    RST_ASSERT = 3'd5
  } carfield_dom_state_e;

  // Next round-robin position after idx, wrapping at NumDomains.
  function automatic logic [DomIdxW-1:0] rr_next(input logic [DomIdxW-1:0] idx);
    if (idx == DomIdxW'(NumDomains - 1)) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/carfield_domain_fsm.sv
// carfield_domain_fsm
//   One domain's sequencing FSM and its down-counter.
//   Ports:
//     clk_i, rst_i      clock, synchronous active-high reset
//     en_i              requested domain state (1=on)
//     idle_i            domain has no outstanding AXI traffic (used in DRAIN only)
//     clr_timeout_i     clears the sticky drain-timeout flag
//     gnt_i             scheduler grant; leave the stable state on the next edge
//     req_o             domain wants to change stable state
//     stable_o          FSM is in OFF or ON (token may be released)
//     clk_en_o, rst_o, iso_o, on_o, busy_o, timeout_o   registered domain controls/status
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   OFF        | clock gated, reset held, boundary isolated
//   CLK_ON     | clock running with reset held, SettleCycles long
//   RST_REL    | reset released, still isolated, RstCycles long
//   ON         | domain fully operational
//   DRAIN      | isolated, waiting for idle_i or DrainTimeout
//   RST_ASSERT | reset re-asserted with clock running, RstCycles long
module carfield_domain_fsm
  import carfield_pkg::*;
#(
  parameter int unsigned SettleCycles = 16,
  parameter int unsigned RstCycles    = 8,
  parameter int unsigned DrainTimeout = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic idle_i,
  input  logic clr_timeout_i,
  input  logic gnt_i,
  output logic req_o,
  output logic stable_o,
  output logic clk_en_o,
  output logic rst_o,
  output logic iso_o,
  output logic on_o,
  output logic busy_o,
  output logic timeout_o
);

  localparam int unsigned MaxSR  = (SettleCycles > RstCycles) ? SettleCycles : RstCycles;
  localparam int unsigned MaxCnt = (MaxSR > DrainTimeout) ? MaxSR : DrainTimeout;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  carfield_dom_state_e state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                timeout_q, timeout_d;
  logic                clk_en_q, clk_en_d;
  logic                rst_q, rst_d;
  logic                iso_q, iso_d;
  logic                on_q, on_d;
  logic                busy_q, busy_d;
  logic                timeout_set;

  assign stable_o = (state_q == OFF) || (state_q == ON);
  assign req_o    = ((state_q == OFF) && en_i) || ((state_q == ON) && !en_i);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timeout_set = 1'b0;
    unique case (state_q)
      OFF: begin
        if (gnt_i) begin
          state_d = CLK_ON;
          cnt_d   = CntW'(SettleCycles - 1);
        end
      end
      CLK_ON: begin
        if (cnt_q == '0) begin
          state_d = RST_REL;
          cnt_d   = CntW'(RstCycles - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RST_REL: begin
        if (cnt_q == '0) begin
          state_d = ON;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ON: begin
        if (gnt_i) begin
          state_d = DRAIN;
          cnt_d   = CntW'(DrainTimeout - 1);
        end
      end
      DRAIN: begin
        // A late idle on the last timeout cycle still counts as a clean drain.
        if (idle_i || (cnt_q == '0)) begin
          state_d     = RST_ASSERT;
          cnt_d       = CntW'(RstCycles - 1);
          timeout_set = !idle_i;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RST_ASSERT: begin
        if (cnt_q == '0) begin
          state_d = OFF;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = OFF;
    endcase

    // Set has priority over a coincident clear.
    if (timeout_set) begin
      timeout_d = 1'b1;
    end else if (clr_timeout_i) begin
      timeout_d = 1'b0;
    end else begin
      timeout_d = timeout_q;
    end

    // Outputs are decoded from the next state so they register alongside it.
    clk_en_d = (state_d != OFF);
    rst_d    = (state_d == OFF) || (state_d == CLK_ON) || (state_d == RST_ASSERT);
    iso_d    = (state_d != ON);
    on_d     = (state_d == ON);
    busy_d   = (state_d != OFF) && (state_d != ON);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= OFF;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      clk_en_q  <= 1'b0;
      rst_q     <= 1'b1;
      iso_q     <= 1'b1;
      on_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      clk_en_q  <= clk_en_d;
      rst_q     <= rst_d;
      iso_q     <= iso_d;
      on_q      <= on_d;
      busy_q    <= busy_d;
    end
  end

  assign clk_en_o  = clk_en_q;
  assign rst_o     = rst_q;
  assign iso_o     = iso_q;
  assign on_o      = on_q;
  assign busy_o    = busy_q;
  assign timeout_o = timeout_q;

endmodule

// File: rtl/carfield_domain_sequencer.sv
// carfield_domain_sequencer
//   Power/clock/reset sequencer for the Carfield accelerator domains
//   (Safety Island, Security Island, Integer Cluster). One FSM per domain;
//   a round-robin token scheduler lets only one domain transition at a time.
//   Ports:
//     clk_i, rst_i       clock, synchronous active-high reset
//     en_i               requested on/off per domain (level)
//     idle_i             domain reports no outstanding AXI transactions
//     clr_timeout_i      pulse clearing timeout_o per domain
//     clk_en_o           domain clock-gate enable
//     domain_rst_o       domain reset, active-high
//     isolate_o          domain boundary clamp, 1=isolated
//     on_o, busy_o       fully on / mid-transition status
//     timeout_o          sticky drain-timeout flag
module carfield_domain_sequencer
  import carfield_pkg::*;
#(
  parameter int unsigned SettleCycles = 16,
  parameter int unsigned RstCycles    = 8,
  parameter int unsigned DrainTimeout = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumDomains-1:0] en_i,
  input  logic [NumDomains-1:0] idle_i,
  input  logic [NumDomains-1:0] clr_timeout_i,
  output logic [NumDomains-1:0] clk_en_o,
  output logic [NumDomains-1:0] domain_rst_o,
  output logic [NumDomains-1:0] isolate_o,
  output logic [NumDomains-1:0] on_o,
  output logic [NumDomains-1:0] busy_o,
  output logic [NumDomains-1:0] timeout_o
);

  if (SettleCycles < 1) begin : g_bad_settle
    $error("SettleCycles must be >= 1");
  end
  if (RstCycles < 1) begin : g_bad_rst
    $error("RstCycles must be >= 1");
  end
  if (DrainTimeout < 1) begin : g_bad_drain
    $error("DrainTimeout must be >= 1");
  end

  logic [NumDomains-1:0] req;
  logic [NumDomains-1:0] stable;
  logic [NumDomains-1:0] gnt;
  logic                  gnt_any;
  logic [DomIdxW-1:0]    gnt_idx;
  int unsigned           cand;

  logic                  tok_vld_q, tok_vld_d;
  logic [DomIdxW-1:0]    tok_idx_q, tok_idx_d;
  logic [DomIdxW-1:0]    ptr_q, ptr_d;
  logic                  token_busy;

  // The token frees itself in the cycle its owner lands in OFF or ON, so a
  // waiting domain can be granted in that very cycle.
  assign token_busy = tok_vld_q && !stable[tok_idx_q];

  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    if (!token_busy) begin
      for (int i = 0; i < NumDomains; i++) begin
        cand = (32'(ptr_q) + 32'(i)) % NumDomains;
        if (!gnt_any && req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = DomIdxW'(cand);
        end
      end
    end
    if (gnt_any) begin
      gnt[gnt_idx] = 1'b1;
    end

    tok_vld_d = tok_vld_q;
    tok_idx_d = tok_idx_q;
    ptr_d     = ptr_q;
    if (gnt_any) begin
      tok_vld_d = 1'b1;
      tok_idx_d = gnt_idx;
      // Advancing at grant time means the next arbitration already starts
      // past this domain.
      ptr_d     = rr_next(gnt_idx);
    end else if (tok_vld_q && stable[tok_idx_q]) begin
      tok_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tok_vld_q <= 1'b0;
      tok_idx_q <= '0;
      ptr_q     <= '0;
    end else begin
      tok_vld_q <= tok_vld_d;
      tok_idx_q <= tok_idx_d;
      ptr_q     <= ptr_d;
    end
  end

  for (genvar d = 0; d < NumDomains; d++) begin : g_dom
    carfield_domain_fsm #(
      .SettleCycles (SettleCycles),
      .RstCycles    (RstCycles),
      .DrainTimeout (DrainTimeout)
    ) u_fsm (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .en_i          (en_i[d]),
      .idle_i        (idle_i[d]),
      .clr_timeout_i (clr_timeout_i[d]),
      .gnt_i         (gnt[d]),
      .req_o         (req[d]),
      .stable_o      (stable[d]),
      .clk_en_o      (clk_en_o[d]),
      .rst_o         (domain_rst_o[d]),
      .iso_o         (isolate_o[d]),
      .on_o          (on_o[d]),
      .busy_o        (busy_o[d]),
      .timeout_o     (timeout_o[d])
    );
  end

endmodule
